// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the data-memory access sequencer.
package mem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b011,
        LHU = 3'b100,
        SB  = 3'b101,
        SH  = 3'b110,
        SW  = 3'b111
    } mem_ctrl_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } seq_state_e;

    function automatic logic is_store(input logic [2:0] ctrl);
        return ctrl[2] & (ctrl[1] | ctrl[0]);
    endfunction

    function automatic logic misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
        logic mis;
        case (mem_ctrl_e'(ctrl))
            LH, LHU, SH: mis = addr_lo[0];
            LW, SW:      mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: little-endian load extract/extend and store
// byte/half merge into a RAM word that has no byte enables.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [2:0]  ctrl_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{addr_i, 3'b000} +: 8];
        half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        load_o = '0;
        case (mem_ctrl_e'(ctrl_i))
            LB:      load_o = {{24{byte_v[7]}}, byte_v};
            LBU:     load_o = {24'h0, byte_v};
            LH:      load_o = {{16{half_v[15]}}, half_v};
            LHU:     load_o = {16'h0, half_v};
            LW:      load_o = rdata_i;
            default: load_o = '0;
        endcase

        // Only the addressed lane changes; the rest of the word is written back as read.
        merged_o = rdata_i;
        case (mem_ctrl_e'(ctrl_i))
            SB: merged_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
            SH: begin
                if (addr_i[1]) merged_o[31:16] = wdata_i[15:0];
                else           merged_o[15:0]  = wdata_i[15:0];
            end
            SW:      merged_o = wdata_i;
            default: merged_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer for a word-wide single-port synchronous RAM.
// Handshake: a request transfers on a rising edge where req_valid & req_ready.
module mem_access_seq
    import mem_pkg::*;
#(
    parameter int SIZE = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_ctrl,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err,
    output logic            mem_en,
    output logic            mem_we,
    output logic [SIZE-3:0] mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata,
    output logic [2:0]      dbg_state_o
);

    seq_state_e      state_q, state_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [SIZE-1:0] addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [31:0]     lane_load, lane_merged;
    logic            accept;
    logic            req_mis;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:SIZE];

    mem_lane_unit u_lane (
        .ctrl_i   (ctrl_q),
        .addr_i   (addr_q[1:0]),
        .rdata_i  (mem_rdata),
        .wdata_i  (wdata_q),
        .load_o   (lane_load),
        .merged_o (lane_merged)
    );

    assign req_ready = ((state_q == IDLE) || (state_q == RSP)) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_mis   = misaligned(req_ctrl, req_addr[1:0]);

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            RD:  state_d = CAP;
            CAP: begin
                if (is_store(ctrl_q)) begin
                    mem_wdata_d = lane_merged;
                    state_d     = WR;
                end else begin
                    rsp_rdata_d = lane_load;
                    state_d     = RSP;
                end
            end
            WR:      state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Accept overrides the RSP->IDLE step so back-to-back requests lose no cycle.
        if (accept) begin
            ctrl_d      = req_ctrl;
            addr_d      = req_addr[SIZE-1:0];
            wdata_d     = req_wdata;
            rsp_rdata_d = '0;
            rsp_err_d   = req_mis;
            if (req_mis) begin
                state_d = RSP;
            end else if (mem_ctrl_e'(req_ctrl) == SW) begin
                mem_wdata_d = req_wdata;
                state_d     = WR;
            end else begin
                state_d = RD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // RAM strobes are suppressed during reset so an interrupted write never lands.
    assign mem_en      = ((state_q == RD) || (state_q == WR)) && !rst;
    assign mem_we      = (state_q == WR) && !rst;
    assign mem_addr    = addr_q[SIZE-1:2];
    assign mem_wdata   = mem_wdata_q;
    assign rsp_valid   = (state_q == RSP) && !rst;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_state_o = state_q;

endmodule
